// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: processes SLICE bits per clock, LSB slice first,
// and publishes sum/cout/ovf only when the whole word is finished.
module seq_slice_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shadow;

  logic [WIDTH-1:0] w_eff_b;
  logic [SLICE:0]   w_slice;
  logic [WIDTH-1:0] w_shadow;

  assign w_eff_b = sub ? ~b : b;

  // Operands shift right each RUN cycle, so the active slice is always the low bits.
  always_comb begin
    w_slice  = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_b[SLICE-1:0]} + {{SLICE{1'b0}}, r_carry};
    w_shadow = r_shadow;
    w_shadow[r_cnt*SLICE +: SLICE] = w_slice[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cnt    <= '0;
      r_shadow <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_eff_b;
            r_carry <= sub ? 1'b1 : cin;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_eff_b[WIDTH-1];
            r_cnt   <= '0;
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          r_a      <= r_a >> SLICE;
          r_b      <= r_b >> SLICE;
          r_carry  <= w_slice[SLICE];
          r_shadow <= w_shadow;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= w_shadow;
            cout    <= w_slice[SLICE];
            ovf     <= (r_a_msb == r_b_msb) && (w_shadow[WIDTH-1] != r_a_msb);
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_slice_adder.md
SEQ_SLICE_ADDER -- requirements
Module: seq_slice_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE slice steps.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to launch an addition; sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract; captured with start.
REQ-007 SHALL have port a  input  WIDTH  operand A, captured with start.
REQ-008 SHALL have port b  input  WIDTH  operand B, captured with start.
REQ-009 SHALL have port cin  input  1  carry-in for add mode, captured with start; ignored when sub=1.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port sum  output  WIDTH  registered result.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge SHALL capture a, b, sub and cin, clear the slice counter, and go to RUN.
REQ-017 Operand capture SHALL set the effective B to ~b and the carry to 1 when sub=1, and to b and cin when sub=0.
REQ-018 RUN SHALL add one SLICE-bit slice per cycle, LSB slice first, with the carry registered between slices.
REQ-019 RUN SHALL write each slice result to an internal shadow register.
REQ-020 RUN SHALL go to DONE on the edge that processes slice N-1.
REQ-021 On entry to DONE, sum SHALL load the shadow register, cout SHALL load the final carry, and ovf SHALL load (A[MSB] == effB[MSB]) && (sum[MSB] != A[MSB]).
REQ-022 DONE SHALL hold done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-023 busy SHALL be 1 in RUN only.
REQ-024 done SHALL be 1 in DONE only.
REQ-025 Latency SHALL be: start accepted at edge k, done high during the cycle following edge k+N, a total of N+1 cycles.
REQ-026 start SHALL be ignored in RUN and DONE, with no queuing and no restart.
REQ-027 Any new a, b, cin or sub value applied while not in IDLE SHALL have no effect on the operation in progress.
REQ-028 sum, cout and ovf SHALL hold their last completed result until the next DONE entry; they SHALL never show partial results.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL be the raw carry, which for subtract equals NOT borrow.
REQ-030 When SLICE = WIDTH (N=1), the block SHALL still take one RUN cycle, giving a latency of 2.

Reset
REQ-031 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter and the shadow register.
REQ-032 rst SHALL take priority over start in the same cycle.
REQ-033 rst asserted during RUN or DONE SHALL abort the operation, with no done pulse for it and outputs cleared.

Verification (WIDTH=16, SLICE=4, N=4)
REQ-034 SHALL verify: rst for 2 cycles -> busy=0, done=0, sum=0x0000, cout=0, ovf=0.
REQ-035 SHALL verify: add a=0x0005, b=0x0008, cin=1 -> done exactly 5 cycles after the start cycle, sum=0x000E, cout=0, ovf=0; busy high for 4 cycles.
REQ-036 SHALL verify: add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; then add a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-037 SHALL verify: sub a=0x8000, b=0x0001, cin=1 (ignored) -> sum=0x7FFF, cout=1, ovf=1; then sub a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0.
REQ-038 SHALL verify: start pulsed again with new operands during RUN -> ignored; the original result is produced, then one IDLE cycle passes before the next start is accepted.
REQ-039 SHALL verify: rst during the 2nd RUN cycle -> busy=0 on the next cycle, no done pulse, sum=0x0000; the next start completes normally.
